// File: rtl/control_unit_decode_if.sv
// ---------------------------------------------------------------------------
// control_unit_decode_if
//   Bundles the opcode that comes in from fetch/decode with the full set of
//   datapath control signals that go out to the execute stage.
//
//   There is no handshake on this bus. Opcode is sampled on every rising
//   clock edge, and every control output is valid from one edge to the next.
//   There is no valid, ready or stall qualifier.
//
//   Modports
//     master : drives Opcode and observes the control word (fetch side / bench)
//     slave  : receives Opcode and drives the control word (the decoder)
// ---------------------------------------------------------------------------
interface control_unit_decode_if;
   logic [4:0] Opcode;
   logic [3:0] ALUOp;
   logic       RegDst;
   logic       ALUSrc;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       RegWrite;
   logic       Branch;
   logic       BranchOp;
   logic       RegSrc1;
   logic       RegSrc2;
   logic       ALUDest;
   logic       PF_op;
   logic       ImmSrc;
   logic       Integer_op;

   modport master (
      output Opcode,
      input  ALUOp, RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite,
             Branch, BranchOp, RegSrc1, RegSrc2, ALUDest, PF_op, ImmSrc,
             Integer_op
   );

   modport slave (
      input  Opcode,
      output ALUOp, RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite,
             Branch, BranchOp, RegSrc1, RegSrc2, ALUDest, PF_op, ImmSrc,
             Integer_op
   );
endinterface

// File: rtl/control_unit_decode.sv
// ---------------------------------------------------------------------------
// control_unit_decode
//   Main decoder of the decode stage. A combinational table maps the 5-bit
//   opcode to the complete control word for the integer, packed-float,
//   memory and branch units. The control word is then registered, so every
//   control output comes straight from a flop.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset; forces the DEFAULT control word
//     bus  : control_unit_decode_if.slave
//              Opcode in; ALUOp[3:0] and the single-bit controls out
//
//   Timing: one cycle from Opcode to the control outputs. There is no enable.
// ---------------------------------------------------------------------------
module control_unit_decode (
   input  logic                        clk,
   input  logic                        rst,
   control_unit_decode_if.slave        bus
);

   typedef struct packed {
      logic [3:0] alu_op;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       branch;
      logic       branch_op;
      logic       reg_src1;
      logic       reg_src2;
      logic       alu_dest;
      logic       pf_op;
      logic       imm_src;
      logic       integer_op;
   } ctrl_t;

   // The DEFAULT word: both read ports are used, the result goes through the
   // ALU destination path, and the ALU is set to address-add. This word is
   // also the decode of every opcode the table does not list.
   localparam ctrl_t CTRL_DEFAULT = '{
      alu_op:     4'b0100,
      reg_dst:    1'b1,
      alu_src:    1'b0,
      mem_read:   1'b0,
      mem_write:  1'b0,
      mem_to_reg: 1'b0,
      reg_write:  1'b0,
      branch:     1'b0,
      branch_op:  1'b0,
      reg_src1:   1'b1,
      reg_src2:   1'b1,
      alu_dest:   1'b1,
      pf_op:      1'b0,
      imm_src:    1'b0,
      integer_op: 1'b0
   };

   ctrl_t ctrl_d;
   ctrl_t ctrl_q;

   // Each row starts from the DEFAULT word and overrides only the fields that
   // differ from it.
   always_comb begin
      ctrl_d = CTRL_DEFAULT;
      unique case (bus.Opcode)
         5'b00000: begin                      // ADD
            ctrl_d.alu_op     = 4'b0000;
            ctrl_d.integer_op = 1'b1;
         end
         5'b00001: begin                      // SUB
            ctrl_d.alu_op     = 4'b0001;
            ctrl_d.integer_op = 1'b1;
         end
         5'b00010: begin                      // MUL
            ctrl_d.alu_op     = 4'b0010;
            ctrl_d.integer_op = 1'b1;
         end
         5'b00011: begin                      // ADDI: operand B is the immediate
            ctrl_d.alu_op     = 4'b0000;
            ctrl_d.alu_src    = 1'b1;
            ctrl_d.imm_src    = 1'b1;
            ctrl_d.reg_src2   = 1'b0;
            ctrl_d.integer_op = 1'b1;
         end
         5'b00100: begin                      // LDR
            ctrl_d.alu_op     = 4'b0100;
            ctrl_d.mem_read   = 1'b1;
            ctrl_d.mem_to_reg = 1'b1;
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.integer_op = 1'b1;
         end
         5'b00101: begin                      // STR: nothing is written back
            ctrl_d.alu_op     = 4'b0100;
            ctrl_d.mem_write  = 1'b1;
            ctrl_d.reg_dst    = 1'b0;
            ctrl_d.alu_dest   = 1'b0;
            ctrl_d.integer_op = 1'b1;
         end
         5'b01000: begin                      // FADD
            ctrl_d.alu_op     = 4'b0000;
            ctrl_d.pf_op      = 1'b1;
         end
         5'b01001: begin                      // FSUB
            ctrl_d.alu_op     = 4'b0001;
            ctrl_d.pf_op      = 1'b1;
         end
         5'b01010: begin                      // FMUL
            ctrl_d.alu_op     = 4'b0010;
            ctrl_d.pf_op      = 1'b1;
         end
         5'b11000, 5'b11001: begin            // BEQ / BNE: compare by subtract
            ctrl_d.alu_op     = 4'b0001;
            ctrl_d.imm_src    = 1'b1;
            ctrl_d.reg_dst    = 1'b0;
            ctrl_d.alu_dest   = 1'b0;
            ctrl_d.branch     = 1'b1;
            ctrl_d.branch_op  = bus.Opcode[0]; // 1 selects not-equal
         end
         default: ctrl_d = CTRL_DEFAULT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ctrl_q <= CTRL_DEFAULT;
      else     ctrl_q <= ctrl_d;
   end

   assign bus.ALUOp      = ctrl_q.alu_op;
   assign bus.RegDst     = ctrl_q.reg_dst;
   assign bus.ALUSrc     = ctrl_q.alu_src;
   assign bus.MemRead    = ctrl_q.mem_read;
   assign bus.MemWrite   = ctrl_q.mem_write;
   assign bus.MemtoReg   = ctrl_q.mem_to_reg;
   assign bus.RegWrite   = ctrl_q.reg_write;
   assign bus.Branch     = ctrl_q.branch;
   assign bus.BranchOp   = ctrl_q.branch_op;
   assign bus.RegSrc1    = ctrl_q.reg_src1;
   assign bus.RegSrc2    = ctrl_q.reg_src2;
   assign bus.ALUDest    = ctrl_q.alu_dest;
   assign bus.PF_op      = ctrl_q.pf_op;
   assign bus.ImmSrc     = ctrl_q.imm_src;
   assign bus.Integer_op = ctrl_q.integer_op;

endmodule

// File: tb/tb_control_unit_decode.sv
// ---------------------------------------------------------------------------
// tb_control_unit_decode
//   Directed test of the opcode decoder. The driver applies one opcode per
//   negative clock edge and pushes the hand-computed control word onto
//   exp_q. The monitor pops one entry on each rising edge that follows a
//   push and compares it with the registered outputs. An invariant checker
//   watches the outputs on every cycle.
//
//   Word layout: {ALUOp[3:0], RegDst, ALUSrc, MemRead, MemWrite, MemtoReg,
//                 RegWrite, Branch, BranchOp, RegSrc1, RegSrc2, ALUDest,
//                 PF_op, ImmSrc, Integer_op}
// ---------------------------------------------------------------------------
module tb_control_unit_decode;

   localparam int W = 18;

   logic clk;
   logic rst;

   control_unit_decode_if bus ();

   control_unit_decode dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   logic [4:0]   op_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- expected table (hand-written words) ----------------
   function automatic logic [W-1:0] expected_word(input logic [4:0] op);
      logic [W-1:0] w;
      case (op)
         5'b00000: w = {4'b0000, 14'b10000000111001}; // ADD
         5'b00001: w = {4'b0001, 14'b10000000111001}; // SUB
         5'b00010: w = {4'b0010, 14'b10000000111001}; // MUL
         5'b00011: w = {4'b0000, 14'b11000000101011}; // ADDI
         5'b00100: w = {4'b0100, 14'b10101100111001}; // LDR
         5'b00101: w = {4'b0100, 14'b00010000110001}; // STR
         5'b01000: w = {4'b0000, 14'b10000000111100}; // FADD
         5'b01001: w = {4'b0001, 14'b10000000111100}; // FSUB
         5'b01010: w = {4'b0010, 14'b10000000111100}; // FMUL
         5'b11000: w = {4'b0001, 14'b00000010110010}; // BEQ
         5'b11001: w = {4'b0001, 14'b00000011110010}; // BNE
         default:  w = {4'b0100, 14'b10000000111000}; // DEFAULT
      endcase
      return w;
   endfunction

   function automatic logic [W-1:0] dut_word();
      return {bus.ALUOp, bus.RegDst, bus.ALUSrc, bus.MemRead, bus.MemWrite,
              bus.MemtoReg, bus.RegWrite, bus.Branch, bus.BranchOp,
              bus.RegSrc1, bus.RegSrc2, bus.ALUDest, bus.PF_op, bus.ImmSrc,
              bus.Integer_op};
   endfunction

   task automatic check_word(input string name, input logic [W-1:0] exp);
      logic [W-1:0] act;
      act = dut_word();
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive_op(input logic [4:0] op);
      @(negedge clk);
      bus.Opcode = op;
      exp_q.push_back(expected_word(op));
      op_q.push_back(op);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(posedge clk) begin
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         logic [4:0]   o;
         e = exp_q.pop_front();
         o = op_q.pop_front();
         #1;
         check_word($sformatf("decode op=%b", o), e);
      end
   end

   // ---------------- invariant checker ----------------
   always @(posedge clk) begin
      #2;
      if (!rst) begin
         total++;
         if (bus.MemRead && bus.MemWrite) begin
            bad++;
            $display("FAIL inv_mem: MemRead=%b MemWrite=%b, required not both 1",
                     bus.MemRead, bus.MemWrite);
         end
         total++;
         if (bus.PF_op && bus.Integer_op) begin
            bad++;
            $display("FAIL inv_unit: PF_op=%b Integer_op=%b, required not both 1",
                     bus.PF_op, bus.Integer_op);
         end
         total++;
         if (bus.Branch && (bus.MemWrite || bus.RegWrite || bus.ALUDest)) begin
            bad++;
            $display("FAIL inv_branch: MemWrite=%b RegWrite=%b ALUDest=%b, required 0 with Branch=1",
                     bus.MemWrite, bus.RegWrite, bus.ALUDest);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] dflt;
      dflt = expected_word(5'b11101);

      rst        = 1'b1;
      bus.Opcode = 5'b00100;
      #1;
      check_word("reset_state", dflt);
      repeat (2) @(posedge clk);
      #1;
      check_word("reset_hold", dflt);
      @(negedge clk);
      rst = 1'b0;

      // directed single vectors
      drive_op(5'b00000);
      drive_op(5'b00100);
      drive_op(5'b01000);
      drive_op(5'b11101);

      // asynchronous reset in the middle of a cycle, after LDR has been decoded
      drive_op(5'b00100);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_word("async_reset_immediate", dflt);
      @(posedge clk);
      #1;
      check_word("async_reset_hold", dflt);
      @(negedge clk);
      rst = 1'b0;

      // sweep every opcode back-to-back, then run the sweep again in reverse
      for (int i = 0; i < 32; i++) drive_op(5'(i));
      for (int i = 31; i >= 0; i--) drive_op(5'(i));

      // let the monitor drain the queue, bounded
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/control_unit_decode.md
Name: control_unit_decode

Overview:
- Main decoder of the decode stage. Maps a 5-bit opcode to the full set of datapath control signals for the integer, packed-float (PF), memory and branch units.
- Decoding is a combinational table lookup. The result is captured in an output register, so every control signal is driven from a flop into the execute stage.

Parameters:
- None. The opcode width (5) and ALUOp width (4) are fixed.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Asynchronous, active-high reset.
- Opcode  in  5  Instruction opcode from fetch/decode.
- ALUOp  out  4  ALU function: 0000 add, 0001 sub, 0010 mul, 0100 address add.
- RegDst  out  1  1 = destination field selects the write register.
- ALUSrc  out  1  1 = ALU operand B is the immediate; 0 = register.
- MemRead  out  1  Data-memory read enable.
- MemWrite  out  1  Data-memory write enable.
- MemtoReg  out  1  1 = writeback data comes from memory.
- RegWrite  out  1  Register-file write enable for memory-load writeback.
- Branch  out  1  Conditional branch instruction.
- BranchOp  out  1  Branch condition: 0 = equal, 1 = not equal.
- RegSrc1  out  1  1 = read port 1 is used.
- RegSrc2  out  1  1 = read port 2 is used.
- ALUDest  out  1  1 = ALU result is written back through the ALU destination path.
- PF_op  out  1  Packed-float unit operation.
- ImmSrc  out  1  1 = immediate extension is active.
- Integer_op  out  1  Integer unit operation.

Behaviour:
- Reset and timing:
  - rst high (asynchronous): all outputs go immediately to the DEFAULT word and hold while rst is high.
  - Otherwise, at each rising clk edge the outputs load the decode of the current Opcode. Latency is 1 cycle; there is no enable or stall.
- Every unlisted field in a row below takes its DEFAULT value.
- DEFAULT word (reset value, and the value for every unlisted opcode, including 11101 and all of 00110-00111, 01011-10111, 11010-11111):
  - RegDst=1, RegSrc1=1, RegSrc2=1, ALUDest=1.
  - ALUOp=0100.
  - ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch, BranchOp, PF_op, ImmSrc, Integer_op all 0.
- Integer ALU ops (Integer_op=1):
  - 00000 ADD: ALUOp=0000.
  - 00001 SUB: ALUOp=0001.
  - 00010 MUL: ALUOp=0010.
  - 00011 ADDI: ALUOp=0000, ALUSrc=1, ImmSrc=1, RegSrc2=0.
  - RegWrite stays 0 for these; ALU results write back via ALUDest.
- 00100 LDR: ALUOp=0100, MemRead=1, MemtoReg=1, RegWrite=1, Integer_op=1.
- 00101 STR: ALUOp=0100, MemWrite=1, RegDst=0, ALUDest=0, Integer_op=1.
- PF ops (PF_op=1, Integer_op=0):
  - 01000 FADD: ALUOp=0000.
  - 01001 FSUB: ALUOp=0001.
  - 01010 FMUL: ALUOp=0010.
- Branches (ALUOp=0001, ImmSrc=1, RegDst=0, ALUDest=0):
  - 11000 BEQ: Branch=1, BranchOp=0.
  - 11001 BNE: Branch=1, BranchOp=1.
- Invariants:
  - MemRead and MemWrite are never both 1.
  - PF_op and Integer_op are never both 1.
  - Branch=1 implies MemWrite=0, RegWrite=0, ALUDest=0.
- Opcode changing every cycle yields a new decode every cycle; the table has no state.

Test Plan:
- Assert rst mid-cycle after decoding LDR -> outputs switch to the DEFAULT word immediately, without waiting for a clock edge.
- Opcode=00000, one edge -> RegDst=1, RegSrc1=1, RegSrc2=1, ALUOp=0000, ALUDest=1, Integer_op=1, all other outputs 0.
- Opcode=00100, one edge -> RegDst=1, RegSrc1=1, RegSrc2=1, ALUOp=0100, MemRead=1, MemtoReg=1, RegWrite=1, ALUDest=1, Integer_op=1, all other outputs 0.
- Opcode=01000, one edge -> RegDst=1, RegSrc1=1, RegSrc2=1, ALUOp=0000, ALUDest=1, PF_op=1, Integer_op=0, all other outputs 0.
- Opcode=11101, one edge -> DEFAULT word (ALUOp=0100, Branch=0, Integer_op=0).
- Sweep all 32 opcodes back-to-back -> each output matches the table exactly one cycle after its opcode is applied, and all invariants hold every cycle.
